// File: rtl/seg_bcd_conv_seq.sv
// Sequential signed/unsigned binary to BCD converter (shift-add-3) with valid/ready input and a one-cycle out_valid pulse.
// Optional leading-zero blanking is built when SEG_BCD_LZB_EN is defined.
module seg_bcd_conv_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    bin,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*DIGITS-1:0] bcd,
  output logic [3:0]          bcd_sgn,
  output logic                ovf,
  output logic                out_valid
);

  function automatic int acc_digits(int w);
    longint unsigned v;
    int n;
    v = 64'd1 << w;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        v = v / 64'd10;
        n++;
      end
    end
    return n + 1;
  endfunction

  function automatic longint unsigned pow10(int d);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < d; i++) p = p * 64'd10;
    return p;
  endfunction

  // Accumulator sized for the full input range so overflow never corrupts the shift.
  localparam int NA0 = acc_digits(WIDTH);
  localparam int NA  = (NA0 > DIGITS) ? NA0 : DIGITS;
  localparam longint unsigned LIMIT = pow10(DIGITS);
  localparam int CW  = $clog2(WIDTH);

`ifdef SEG_BCD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    sh;
  logic [4*NA-1:0]     acc, acc_adj;
  logic                neg_r, ovf_r;
  logic                accept, load;
  logic                neg_in;
  logic [WIDTH-1:0]    mag_in;
  logic [4*DIGITS-1:0] res;
  logic                lead;

  assign neg_in = (SIGNED != 0) && bin[WIDTH-1];
  assign mag_in = neg_in ? -bin : bin;
  assign accept = in_valid & in_ready;

  for (genvar d = 0; d < NA; d++) begin : g_add3
    assign acc_adj[4*d +: 4] = (acc[4*d +: 4] >= 4'd5) ? acc[4*d +: 4] + 4'd3 : acc[4*d +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = S_SHIFT;
      S_SHIFT: if (cnt == CW'(WIDTH-1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    load     = 1'b0;
    case (state)
      S_IDLE:  in_ready = 1'b1;
      S_DONE:  load     = 1'b1;
      default: ;
    endcase
  end

  // Saturate on overflow; blanking scans from the MSD and stops at the first non-zero digit.
  always_comb begin
    res  = ovf_r ? {DIGITS{4'h9}} : acc[4*DIGITS-1:0];
    lead = 1'b1;
    if (LZB && !ovf_r) begin
      for (int d = DIGITS-1; d >= 1; d--) begin
        if (lead && res[4*d +: 4] == 4'd0) res[4*d +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sh        <= '0;
      acc       <= '0;
      neg_r     <= 1'b0;
      ovf_r     <= 1'b0;
      bcd       <= '0;
      bcd_sgn   <= 4'b1111;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= load;
      if (accept) begin
        cnt   <= '0;
        sh    <= mag_in;
        acc   <= '0;
        neg_r <= neg_in;
        ovf_r <= 64'(mag_in) >= LIMIT;
      end else if (state == S_SHIFT) begin
        cnt <= cnt + CW'(1);
        sh  <= {sh[WIDTH-2:0], 1'b0};
        acc <= {acc_adj[4*NA-2:0], sh[WIDTH-1]};
      end
      if (load) begin
        bcd     <= res;
        bcd_sgn <= neg_r ? 4'b1010 : 4'b1111;
        ovf     <= ovf_r;
      end
    end
  end

endmodule
